// File: rtl/score_rx_pkg.sv
// score_rx_pkg: shared constants, FSM state type and helpers for the score frame receiver.
package score_rx_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 6;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        GET_ID  = 3'd1,
        GET_D12 = 3'd2,
        GET_D34 = 3'd3,
        GET_D56 = 3'd4,
        GET_CHK = 3'd5
    } rx_state_e;

    // Returns {lo_id, hi_id}: the two remote players, ordered by ID.
    function automatic logic [3:0] map_slots(input logic [1:0] own);
        return own == 2'b01 ? {2'd2, 2'd3} :
               own == 2'b10 ? {2'd1, 2'd3} : {2'd1, 2'd2};
    endfunction

    function automatic logic bcd_ok(input logic [23:0] d);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++)
            ok &= (d[i*4 +: 4] <= 4'd9);
        return ok;
    endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// rx_gap_timer: clearable up-counter that pulses o_tc once on reaching MAX-1, then saturates.
module rx_gap_timer #(
    parameter int unsigned MAX = 650_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] r_cnt;

    // Parking one past MAX-1 keeps the terminal pulse single-shot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en && r_cnt != W'(MAX))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = i_en && !i_clr && r_cnt == W'(MAX - 1);

endmodule

// File: rtl/score_frame_rx.sv
// score_frame_rx: assembles and validates 6-byte remote score frames into two slot words.
// Optional stale-score clearing is enabled by defining SCORE_RX_STALE_CLEAR_EN.
module score_frame_rx
    import score_rx_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 650_000
`ifdef SCORE_RX_STALE_CLEAR_EN
   ,parameter int unsigned STALE_CYCLES   = 130_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [1:0]  own_id,
    output logic [31:0] ext_data_1,
    output logic [31:0] ext_data_2,
    output logic        upd_1,
    output logic        upd_2,
    output logic        frame_err
);

    rx_state_e   r_state;
    logic [7:0]  r_id, r_d12, r_d34, r_d56;
    logic [23:0] r_dig1, r_dig2;
    logic        r_upd1, r_upd2, r_err;

    logic [1:0]  w_own, w_lo, w_hi;
    logic        w_last, w_id_ok, w_accept, w_wr1, w_wr2, w_timeout, w_clr1, w_clr2;

    assign w_own      = own_id == 2'b00 ? 2'b11 : own_id;
    assign {w_lo, w_hi} = map_slots(own_id);
    assign w_last     = rx_valid && r_state == GET_CHK;
    assign w_id_ok    = r_id[7:2] == 6'd0 && r_id[1:0] != 2'd0 && r_id[1:0] != w_own;
    assign w_accept   = w_last && w_id_ok && (r_id ^ r_d12 ^ r_d34 ^ r_d56) == rx_data
                        && bcd_ok({r_d12, r_d34, r_d56});
    assign w_wr1      = w_accept && r_id[1:0] == w_lo;
    assign w_wr2      = w_accept && r_id[1:0] == w_hi;

    rx_gap_timer #(.MAX(TIMEOUT_CYCLES)) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (rx_valid),
        .i_en  (r_state != HUNT),
        .o_tc  (w_timeout)
    );

`ifdef SCORE_RX_STALE_CLEAR_EN
    rx_gap_timer #(.MAX(STALE_CYCLES)) u_age1 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_wr1),
        .i_en  (1'b1),
        .o_tc  (w_clr1)
    );
    rx_gap_timer #(.MAX(STALE_CYCLES)) u_age2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_wr2),
        .i_en  (1'b1),
        .o_tc  (w_clr2)
    );
`else
    assign w_clr1 = 1'b0;
    assign w_clr2 = 1'b0;
`endif

    // A byte arriving on the timeout cycle takes priority over abandoning the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_id    <= '0;
            r_d12   <= '0;
            r_d34   <= '0;
            r_d56   <= '0;
            r_dig1  <= '0;
            r_dig2  <= '0;
            r_upd1  <= 1'b0;
            r_upd2  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (rx_valid)
                r_state <= r_state == HUNT    ? (rx_data == SYNC_BYTE ? GET_ID : HUNT) :
                           r_state == GET_CHK ? HUNT : rx_state_e'(r_state + 3'd1);
            else if (w_timeout)
                r_state <= HUNT;
            if (rx_valid && r_state == GET_ID)
                r_id <= rx_data;
            if (rx_valid && r_state == GET_D12)
                r_d12 <= rx_data;
            if (rx_valid && r_state == GET_D34)
                r_d34 <= rx_data;
            if (rx_valid && r_state == GET_D56)
                r_d56 <= rx_data;
            r_dig1 <= w_wr1 ? {r_d12, r_d34, r_d56} : w_clr1 ? 24'd0 : r_dig1;
            r_dig2 <= w_wr2 ? {r_d12, r_d34, r_d56} : w_clr2 ? 24'd0 : r_dig2;
            r_upd1 <= w_wr1 || w_clr1;
            r_upd2 <= w_wr2 || w_clr2;
            r_err  <= (w_last && !w_accept) || (w_timeout && !rx_valid);
        end
    end

    assign ext_data_1 = {6'b0, w_lo, r_dig1};
    assign ext_data_2 = {6'b0, w_hi, r_dig2};
    assign upd_1      = r_upd1;
    assign upd_2      = r_upd2;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_score_frame_rx.sv
// tb_score_frame_rx: directed frames checked every cycle against a byte-queue model of the receiver.
module tb_score_frame_rx;

    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [1:0]  own_id = 2'b01;
    logic [31:0] ext_data_1, ext_data_2;
    logic        upd_1, upd_2, frame_err;

    int checks = 0;
    int fails = 0;
    int err_seen = 0;
    int e0;

    always #5 clk = ~clk;

    score_frame_rx #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .own_id     (own_id),
        .ext_data_1 (ext_data_1),
        .ext_data_2 (ext_data_2),
        .upd_1      (upd_1),
        .upd_2      (upd_2),
        .frame_err  (frame_err)
    );

    function automatic int own_eff(input logic [1:0] o);
        return o == 2'd0 ? 3 : int'(o);
    endfunction

    function automatic logic [1:0] lo_of(input logic [1:0] o);
        return own_eff(o) == 1 ? 2'd2 : 2'd1;
    endfunction

    function automatic logic [1:0] hi_of(input logic [1:0] o);
        return own_eff(o) == 3 ? 2'd2 : 2'd3;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
        end
    endtask

    logic [7:0]  q[$];
    int          gap;
    int          m_id;
    logic        m_ok;
    logic [23:0] m_d1, m_d2;
    logic        m_u1, m_u2, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            gap = 0;
            m_d1 = '0;
            m_d2 = '0;
            m_u1 = 1'b0;
            m_u2 = 1'b0;
            m_err = 1'b0;
        end else begin
            m_u1 = 1'b0;
            m_u2 = 1'b0;
            m_err = 1'b0;
            if (rx_valid) begin
                gap = 0;
                if (q.size() != 0 || rx_data == 8'hA5)
                    q.push_back(rx_data);
                if (q.size() == 6) begin
                    m_id = int'(q[1]);
                    m_ok = ((q[1] ^ q[2] ^ q[3] ^ q[4]) == q[5]) && m_id >= 1 && m_id <= 3
                           && m_id != own_eff(own_id);
                    for (int i = 2; i < 5; i++)
                        if (q[i][7:4] > 4'd9 || q[i][3:0] > 4'd9) m_ok = 1'b0;
                    if (!m_ok)
                        m_err = 1'b1;
                    else if (m_id == int'(lo_of(own_id))) begin
                        m_d1 = {q[2], q[3], q[4]};
                        m_u1 = 1'b1;
                    end else begin
                        m_d2 = {q[2], q[3], q[4]};
                        m_u2 = 1'b1;
                    end
                    q.delete();
                end
            end else if (q.size() != 0) begin
                gap++;
                if (gap == T) begin
                    m_err = 1'b1;
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ext_data_1", ext_data_1, {6'b0, lo_of(own_id), m_d1});
        chk("ext_data_2", ext_data_2, {6'b0, hi_of(own_id), m_d2});
        chk("flags", {29'b0, upd_1, upd_2, frame_err}, {29'b0, m_u1, m_u2, m_err});
        if (frame_err) err_seen++;
    end

    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #2 rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [47:0] f, input int spacing);
        for (int i = 0; i < 6; i++) begin
            put(f[47 - 8*i -: 8]);
            if (i < 5) idle(spacing);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #3;
        chk("rst_ext1", ext_data_1, 32'h02000000);
        chk("rst_ext2", ext_data_2, 32'h03000000);
        chk("rst_flags", {29'b0, upd_1, upd_2, frame_err}, 32'h0);

        send(48'hA5_02_12_34_56_72, 1);
        #3;
        chk("t1_upd1", {31'b0, upd_1}, 32'h1);
        chk("t1_ext1", ext_data_1, 32'h02123456);
        chk("t1_ext2", ext_data_2, 32'h03000000);
        idle(1);
        #3 chk("t1_upd1_end", {31'b0, upd_1}, 32'h0);

        send(48'hA5_03_00_00_99_9A, 0);
        #3;
        chk("t2_upd2", {31'b0, upd_2}, 32'h1);
        chk("t2_ext2", ext_data_2, 32'h03000099);

        e0 = err_seen;
        send(48'hA5_02_12_34_56_73, 0);
        send(48'hA5_02_1A_34_56_7A, 0);
        send(48'hA5_01_12_34_56_71, 0);
        idle(2);
        chk("t3_errs", err_seen - e0, 3);
        chk("t3_ext1", ext_data_1, 32'h02123456);
        chk("t3_ext2", ext_data_2, 32'h03000099);

        e0 = err_seen;
        put(8'hA5); put(8'h02); put(8'h12);
        idle(T + 5);
        chk("t4_timeout_err", err_seen - e0, 1);
        send(48'hA5_02_98_76_54_B8, 0);
        #3 chk("t4_ext1", ext_data_1, 32'h02987654);

        e0 = err_seen;
        put(8'hA5); put(8'h02);
        idle(T);
        idle(2);
        chk("t5_exact_timeout", err_seen - e0, 1);
        e0 = err_seen;
        put(8'hA5); put(8'h02);
        idle(T - 1);
        put(8'h55); put(8'h55); put(8'h55); put(8'h57);
        #3;
        chk("t5_late_byte_ext1", ext_data_1, 32'h02555555);
        chk("t5_no_err", err_seen - e0, 0);

        own_id = 2'b00;
        idle(1);
        #3;
        chk("t6_remap_ext1", ext_data_1, 32'h01555555);
        chk("t6_remap_ext2", ext_data_2, 32'h02000099);
        e0 = err_seen;
        send(48'hA5_03_11_11_11_12, 0);
        idle(2);
        chk("t6_own3_err", err_seen - e0, 1);
        send(48'hA5_01_22_33_44_54, 0);
        #3 chk("t6_id1_ext1", ext_data_1, 32'h01223344);

        own_id = 2'b01;
        put(8'hA5); put(8'h02); put(8'h12); put(8'h34);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        put(8'h56); put(8'h72);
        idle(2);
        #3;
        chk("t7_ext1", ext_data_1, 32'h02000000);
        chk("t7_ext2", ext_data_2, 32'h03000000);
        chk("t7_flags", {29'b0, upd_1, upd_2, frame_err}, 32'h0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
